// File: rtl/seq_shift_add_mult_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier.
package seq_shift_add_mult_pkg;

    localparam int MULT_N = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_shift_add_mult_addstep.sv
// One partial-product step: conditionally add the multiplicand into the
// (N+1)-bit accumulator, carry landing in the top bit.
module mult_addstep #(
    parameter int N = 8
) (
    input  logic [N:0]   acc,
    input  logic [N-1:0] mcand,
    input  logic         en,
    output logic [N:0]   upper
);

    assign upper = acc + (en ? {1'b0, mcand} : {(N+1){1'b0}});

endmodule

// File: rtl/seq_shift_add_mult.sv
// Unsigned N x N shift-and-add multiplier, one add per clock, with a
// start/busy/done handshake and a product register held between runs.
module seq_shift_add_mult
    import seq_shift_add_mult_pkg::*;
#(
    parameter int N = MULT_N
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [N-1:0]   A,
    input  logic [N-1:0]   B,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product
);

    localparam int CW = $clog2(N + 1);

    state_t         state, state_n;
    logic [2*N:0]   p;
    logic [2*N:0]   p_step;
    logic [N-1:0]   mcand;
    logic [CW-1:0]  count;
    logic [N:0]     upper;
    logic           last;

    mult_addstep #(.N(N)) u_addstep (
        .acc   (p[2*N:N]),
        .mcand (mcand),
        .en    (p[0]),
        .upper (upper)
    );

    // P is {acc, mplr}; the low half retires multiplier bits as it shifts.
    assign p_step = {upper, p[N-1:0]} >> 1;
    assign last   = (count == CW'(N - 1));

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  if (start) state_n = S_RUN;
            S_RUN:   if (last)  state_n = S_DONE;
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            p       <= '0;
            mcand   <= '0;
            count   <= '0;
            product <= '0;
        end else begin
            state <= state_n;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mcand <= A;
                        p     <= {{(N+1){1'b0}}, B};
                        count <= '0;
                    end
                end
                S_RUN: begin
                    p     <= p_step;
                    count <= count + CW'(1);
                    // Publish only the final step so partial sums never reach product.
                    if (last) product <= p_step[2*N-1:0];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/seq_shift_add_mult.md
Name: seq_shift_add_mult

Overview:
Unsigned N x N sequential shift-and-add multiplier: one partial-product add per clock, 2N-bit product.
- Built around an N-bit carry-producing adder step; the step's (N+1)-bit sum width matches the team's CLA adder output convention.
- Sits directly downstream of the operand source and produces the "product" value the adder testbenches already print.
- Start/busy/done handshake; the product register holds its value until the next accepted start.

Parameters:
N, 8, operand width in bits (N >= 2); product width is 2N, step counter width is clog2(N+1).

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request a multiply; sampled only in IDLE
A  input  N  multiplicand, unsigned, captured on accepted start
B  input  N  multiplier, unsigned, captured on accepted start
busy  output  1  high in RUN and DONE states
done  output  1  single-cycle pulse, product valid
product  output  2N  result; registered, stable from done until next accepted start

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE, internal P register=0, multiplicand register=0, count=0.
  - Outputs: busy=0, done=0, product=0.
  - Reset overrides start and aborts any operation in flight; there is no partial result.
- States:
  - IDLE: start=1 -> capture mcand<=A, P<={(N+1)'b0, B}, count<=0, go to RUN. start=0 -> stay; product holds.
  - RUN: each cycle executes one step and count<=count+1. After the step with count==N-1, go to DONE.
  - DONE: done=1 for exactly this cycle, product=P[2N-1:0], then IDLE unconditionally.
- P register: 2N+1 bits = {acc[N:0], mplr[N-1:0]}.
- Step:
  - upper = P[2N:N] + (P[0] ? {1'b0, mcand} : 0), computed at N+1 bits; the carry lands in the top bit.
  - P <= {upper, P[N-1:0]} >> 1, a logical right shift with zero fill.
  - No overflow is possible; the final P[2N] is always 0.
- Latency: start accepted at edge t -> done high in the cycle after edge t+N. That is N+1 cycles from accept to done; back-to-back throughput is one result per N+2 cycles.
- product updates only on entry to DONE, so mid-operation P values are never visible on product.
- start while busy (RUN or DONE) is ignored; it is not queued. A and B are don't-care outside the accepting cycle.
- start held high continuously re-triggers on the IDLE cycle after each DONE.
- Zero operands take the full N cycles; there is no early termination.
- busy=1 in RUN and DONE; busy=0 in IDLE. done is never high in IDLE or RUN.

Decomposition:
- Shared package holds:
  - state encoding localparams: S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2
  - default operand width constant MULT_N=8
- One natural sub-module, mult_addstep (parameter N). Purely combinational: inputs acc[N:0], mcand[N-1:0], en; output upper[N:0].
- The FSM, counter and P register stay in the top module.

Test Plan:
- Reset held 3 cycles, then released with start=0 -> busy=0, done=0, product=16'h0000; stays idle for 10 cycles.
- N=8, A=8'h33, B=8'h1E, start pulsed 1 cycle -> busy high for 9 cycles; done pulses exactly once, 9 cycles after the accept edge; product=16'h05FA, held after done.
- A=8'hFF, B=8'hFF -> product=16'hFE01 (max carry path). Then A=8'h55, B=8'h32 back-to-back with start held high -> product=16'h109A; the second done comes N+2 cycles after the first.
- A=8'h00, B=8'hA7 and A=8'hA7, B=8'h01 -> product=16'h0000 and 16'h00A7; each takes the full latency.
- Pulse start with A=8'h12, B=8'h34 while busy, during an 8'h33*8'h1E run -> that run still yields 16'h05FA; no extra done; the second request is dropped.
- Reset asserted in RUN at count=4 -> next cycle busy=0, done=0, product=0. A new start of 8'h0F*8'h0F then yields 16'h00E1.
